// File: rtl/display_scanner.sv
// display_scanner: multiplexed 6-digit HH:MM:SS seven-segment driver with
// frame-synchronous input capture and alert-driven display/buzzer blinking.
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   display_*    binary hour/minute/second from the clock core
//   hour_format  1 = 12-hour mode, 0 = 24-hour mode
//   is_pm        PM flag
//   alarm_buzzer, timer_buzzer  alert requests
//   seg          {g,f,e,d,c,b,a} active-low segments
//   an           one-hot active-low digit enables, an[5]=hour tens .. an[0]=sec ones
//   dp           active-low separator dot
//   pm_led       PM indicator
//   buzzer_out   gated buzzer drive
module display_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] display_hour,
  input  logic [7:0] display_min,
  input  logic [7:0] display_sec,
  input  logic       hour_format,
  input  logic       is_pm,
  input  logic       alarm_buzzer,
  input  logic       timer_buzzer,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp,
  output logic       pm_led,
  output logic       buzzer_out
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'h7F;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_hour_q, sh_hour_d, sh_min_q, sh_min_d, sh_sec_q, sh_sec_d;
  logic          sh_fmt_q, sh_fmt_d, sh_pm_q, sh_pm_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic          dp_q, dp_d, buzzer_q, buzzer_d;
  logic          tick, wrap, alert, hour_bad, field_bad;
  logic [7:0]    field, ones_full;
  logic [3:0]    tens, digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = BLANK;
    endcase
  endfunction

  // Tens digit by threshold compare; keeps the BCD split within 8 bits.
  function automatic logic [3:0] tens_of(input logic [7:0] v);
    tens_of = 4'd0;
    for (int k = 1; k < 10; k++)
      if (v >= 8'(10 * k)) tens_of = 4'(k);
  endfunction

  always_comb begin
    tick      = presc_q == PW'(SCAN_DIV - 1);
    wrap      = tick && idx_q == 3'd5;
    alert     = alarm_buzzer | timer_buzzer;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = wrap ? 3'd0 : tick ? idx_q + 3'd1 : idx_q;
    sh_hour_d = wrap ? display_hour : sh_hour_q;
    sh_min_d  = wrap ? display_min : sh_min_q;
    sh_sec_d  = wrap ? display_sec : sh_sec_q;
    sh_fmt_d  = wrap ? hour_format : sh_fmt_q;
    sh_pm_d   = wrap ? is_pm : sh_pm_q;
    blink_d   = blink_q;
    phase_d   = phase_q;
    if (!alert) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (wrap) begin
      blink_d = blink_q == BW'(BLINK_FRAMES - 1) ? '0 : blink_q + 1'b1;
      phase_d = blink_q == BW'(BLINK_FRAMES - 1) ? ~phase_q : phase_q;
    end
    hour_bad  = sh_fmt_q ? (sh_hour_q == 8'd0 || sh_hour_q > 8'd12) : sh_hour_q > 8'd23;
    field     = idx_q < 3'd2 ? sh_hour_q : idx_q < 3'd4 ? sh_min_q : sh_sec_q;
    field_bad = idx_q < 3'd2 ? hour_bad : field > 8'd59;
    tens      = tens_of(field);
    ones_full = field - ({1'b0, tens, 3'b000} + {3'b000, tens, 1'b0});
    digit     = idx_q[0] ? ones_full[3:0] : tens;
    // Dash wins over the leading-zero blank; 12-hour hour 0 is out of range.
    seg_d     = field_bad ? DASH
              : (idx_q == 3'd0 && sh_fmt_q && sh_hour_q < 8'd10) ? BLANK
              : seg7(digit);
    an_d      = (alert && !phase_q) ? 6'h3F : ~(6'b100000 >> idx_q);
    dp_d      = an_d[4] & an_d[2];
    buzzer_d  = alert & phase_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      sh_hour_q <= '0;
      sh_min_q  <= '0;
      sh_sec_q  <= '0;
      sh_fmt_q  <= 1'b0;
      sh_pm_q   <= 1'b0;
      blink_q   <= '0;
      phase_q   <= 1'b1;
      seg_q     <= BLANK;
      an_q      <= 6'h3F;
      dp_q      <= 1'b1;
      buzzer_q  <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      sh_hour_q <= sh_hour_d;
      sh_min_q  <= sh_min_d;
      sh_sec_q  <= sh_sec_d;
      sh_fmt_q  <= sh_fmt_d;
      sh_pm_q   <= sh_pm_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      buzzer_q  <= buzzer_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign pm_led     = sh_fmt_q & sh_pm_q;
  assign buzzer_out = buzzer_q;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: randomized check of display_scanner against a time-based reference model.
module tb_display_scanner;
  localparam int S  = 4;
  localparam int BF = 2;

  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] hr = '0, mn = '0, sc = '0;
  logic       fmt = 1'b0, pm = 1'b0, alarm = 1'b0, timer = 1'b0;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp, pm_led, buzzer_out;
  int         n_chk = 0, n_fail = 0;
  bit         chk_en = 1'b0;

  display_scanner #(.SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .display_hour(hr), .display_min(mn), .display_sec(sc),
    .hour_format(fmt), .is_pm(pm), .alarm_buzzer(alarm), .timer_buzzer(timer),
    .seg(seg), .an(an), .dp(dp), .pm_led(pm_led), .buzzer_out(buzzer_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model: scan position is pure arithmetic on cycles since reset
  // release; blink phase is the parity of completed BF-frame groups since alert rose.
  int         t = 0, wraps = 0;
  logic [7:0] m_h = '0, m_m = '0, m_s = '0;
  logic       m_fmt = 1'b0, m_pm = 1'b0;
  logic [6:0] e_seg = 7'h7F;
  logic [5:0] e_an = 6'h3F;
  logic       e_dp = 1'b1, e_buz = 1'b0;

  function automatic logic [6:0] digit_seg(input int idx);
    int v;
    bit bad;
    v   = idx < 2 ? int'(m_h) : idx < 4 ? int'(m_m) : int'(m_s);
    bad = idx < 2 ? (m_fmt ? (v == 0 || v > 12) : v > 23) : v > 59;
    if (bad) return 7'b0111111;
    if (idx == 0 && m_fmt && v < 10) return 7'h7F;
    return lut[(idx % 2 == 0) ? v / 10 : v % 10];
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      t = 0; wraps = 0;
      m_h = '0; m_m = '0; m_s = '0; m_fmt = 1'b0; m_pm = 1'b0;
      e_seg = 7'h7F; e_an = 6'h3F; e_dp = 1'b1; e_buz = 1'b0;
    end else begin
      int idx;
      bit al, ph, wr;
      idx   = (t / S) % 6;
      wr    = (t % (6 * S)) == 6 * S - 1;
      al    = alarm || timer;
      ph    = ((wraps / BF) % 2) == 0;
      e_an  = (al && !ph) ? 6'h3F : ~(6'b100000 >> idx);
      e_dp  = !(e_an[4] == 1'b0 || e_an[2] == 1'b0);
      e_buz = al && ph;
      e_seg = digit_seg(idx);
      if (wr) begin
        m_h = hr; m_m = mn; m_s = sc; m_fmt = fmt; m_pm = pm;
      end
      wraps = al ? wraps + (wr ? 1 : 0) : 0;
      t++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("seg", 32'(seg), 32'(e_seg));
      chk("an", 32'(an), 32'(e_an));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("pm_led", 32'(pm_led), 32'(m_fmt && m_pm));
      chk("buzzer", 32'(buzzer_out), 32'(e_buz));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m, input int s, input bit f, input bit p);
    hr = 8'(h); mn = 8'(m); sc = 8'(s); fmt = f; pm = p;
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'h3F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_pm", 32'(pm_led), 32'd0);
    chk("rst_buz", 32'(buzzer_out), 32'd0);
    cycles(hold);
    #2 reset = 1'b1;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("por_seg", 32'(seg), 32'h7F);
    chk("por_an", 32'(an), 32'h3F);
    chk("por_dp", 32'(dp), 32'd1);
    chk("por_buz", 32'(buzzer_out), 32'd0);
    chk_en = 1'b1;
    cycles(2);
    #2 reset = 1'b1;
    set_time(23, 59, 58, 1'b0, 1'b0);
    cycles(72);
    set_time(9, 30, 15, 1'b1, 1'b1);
    cycles(10);
    set_time(12, 60, 7, 1'b1, 1'b0);
    cycles(50);
    set_time(0, 45, 59, 1'b1, 1'b1);
    cycles(50);
    set_time(24, 0, 77, 1'b0, 1'b1);
    cycles(50);
    set_time(10, 5, 0, 1'b1, 1'b1);
    alarm = 1'b1;
    cycles(200);
    alarm = 1'b0;
    cycles(13);
    alarm = 1'b1;
    timer = 1'b1;
    cycles(110);
    alarm = 1'b0;
    cycles(30);
    timer = 1'b0;
    cycles(7);
    pulse_reset(3);
    cycles(40);
    alarm = 1'b1;
    cycles(60);
    pulse_reset(1);
    cycles(30);
    alarm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0)
        set_time(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 24)),
                 int'($urandom_range(0, 70)), int'($urandom_range(0, 70)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 79) == 0) alarm = ~alarm;
      if ($urandom_range(0, 119) == 0) timer = ~timer;
      if ($urandom_range(0, 999) == 0) pulse_reset(int'($urandom_range(1, 4)));
    end
    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
